multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_ch.sv | 166 ++++++++++++++++
 rtl/multi_debounce.sv | 39 +++
 tb/tb_multi_debounce.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the button debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } ch_state_e;

  // Width of a counter that must reach max_period without wrapping.
  function automatic int cnt_width(input int max_period);
    return $clog2(max_period) + 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: 2-flop synchroniser, press/release FSM, pulse and auto-repeat timers.
// Latency: level and press pulse appear DEBOUNCE_PERIOD+2 cycles after the first stable raw sample.
// Backpressure: none; a repeat request while a pulse is in flight is dropped, press/release preempt.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_PERIOD = 62_500_000,
  parameter int PULSE_PER       = 2,
  parameter int HOLD_PERIOD     = 125_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic repeat_en,
  input  logic button,
  output logic level,
  output logic result,
  output logic rel_pulse
);

  localparam int CW = cnt_width(max4(DEBOUNCE_PERIOD, PULSE_PER, HOLD_PERIOD, REPEAT_PERIOD));

  logic          sync1_q, sync2_q;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rep_q, rep_d;         // 0: waiting HOLD_PERIOD, 1: repeating every REPEAT_PERIOD
  logic          pul_q, pul_d;         // a pulse is in flight
  logic          pul_rel_q, pul_rel_d; // in-flight pulse is a release pulse
  logic [CW-1:0] pw_cnt_q, pw_cnt_d;   // remaining pulse cycles after the current one
  logic          start_press, start_rel, start_rep;

  // Raw button into the clock domain; sync2_q is the only level the FSM sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Channel FSM: debounce counting, hold/repeat timing and pulse start requests.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_d       = rep_q;
    start_press = 1'b0;
    start_rel   = 1'b0;
    start_rep   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        db_cnt_d   = '0;
        hold_cnt_d = '0;
        rep_d      = 1'b0;
        if (sync2_q) begin
          // The cycle that leaves IDLE is the first stable cycle.
          if (DEBOUNCE_PERIOD == 1) begin
            state_d     = ST_HELD;
            start_press = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (int'(db_cnt_q) >= DEBOUNCE_PERIOD - 2) begin
          state_d     = ST_HELD;
          db_cnt_d    = '0;
          start_press = 1'b1;
        end else begin
          db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        db_cnt_d = '0;
        if (!sync2_q) begin
          if (DEBOUNCE_PERIOD == 1) begin
            state_d    = ST_IDLE;
            start_rel  = 1'b1;
            hold_cnt_d = '0;
            rep_d      = 1'b0;
          end else begin
            state_d = ST_RELEASE_WAIT;
          end
        end else if (!repeat_en) begin
          hold_cnt_d = '0;
          rep_d      = 1'b0;
        end else if (int'(hold_cnt_q) >= (rep_q ? REPEAT_PERIOD : HOLD_PERIOD) - 1) begin
          start_rep  = 1'b1;
          hold_cnt_d = '0;
          rep_d      = 1'b1;
        end else begin
          hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // Hold timer is frozen here so a short release glitch resumes the repeat cadence.
        if (!repeat_en) begin
          hold_cnt_d = '0;
          rep_d      = 1'b0;
        end
        if (sync2_q) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else if (int'(db_cnt_q) >= DEBOUNCE_PERIOD - 2) begin
          state_d    = ST_IDLE;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          rep_d      = 1'b0;
          start_rel  = 1'b1;
        end else begin
          db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulse generator: fixed-width pulses, never extended by a new request.
  always_comb begin
    pul_d     = pul_q;
    pul_rel_d = pul_rel_q;
    pw_cnt_d  = pw_cnt_q;
    if (pul_q) begin
      if (pw_cnt_q == '0) pul_d = 1'b0;
      else                pw_cnt_d = pw_cnt_q - CW'(1);
    end
    if (start_press || start_rel || (start_rep && !pul_q)) begin
      pul_d     = 1'b1;
      pul_rel_d = start_rel;
      pw_cnt_d  = CW'(PULSE_PER - 1);
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_q      <= 1'b0;
      pul_q      <= 1'b0;
      pul_rel_q  <= 1'b0;
      pw_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_q      <= rep_d;
      pul_q      <= pul_d;
      pul_rel_q  <= pul_rel_d;
      pw_cnt_q   <= pw_cnt_d;
    end
  end

  assign level     = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign result    = pul_q & ~pul_rel_q;
  assign rel_pulse = pul_q & pul_rel_q;

endmodule

// File: rtl/multi_debounce.sv
// NUM_CH independent button debouncers with press, auto-repeat and release pulses.
// Latency: DEBOUNCE_PERIOD+2 cycles from first stable raw sample to level/press pulse.
// Backpressure: none; outputs are free-running pulses and levels.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_PERIOD = 62_500_000,
  parameter int PULSE_PER       = 2,
  parameter int HOLD_PERIOD     = 125_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              repeat_en,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] result,
  output logic [NUM_CH-1:0] rel_pulse
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_PERIOD(DEBOUNCE_PERIOD),
      .PULSE_PER      (PULSE_PER),
      .HOLD_PERIOD    (HOLD_PERIOD),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .repeat_en(repeat_en),
      .button   (button[g]),
      .level    (level[g]),
      .result   (result[g]),
      .rel_pulse(rel_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with short periods.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_debounce;

  logic       clk;
  logic       rst;
  logic       repeat_en;
  logic [3:0] button;
  logic [3:0] level;
  logic [3:0] result;
  logic [3:0] rel_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  multi_debounce #(
    .NUM_CH         (4),
    .DEBOUNCE_PERIOD(4),
    .PULSE_PER      (2),
    .HOLD_PERIOD    (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .repeat_en(repeat_en),
    .button   (button),
    .level    (level),
    .result   (result),
    .rel_pulse(rel_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [50:1] res_v, rel_v, exp_res, exp_rel;
  logic [3:0]  acc;
  logic        lvl_and, rel_or;

  initial begin
    rst       = 1'b0;
    repeat_en = 1'b0;
    button    = 4'b0000;

    // Reset state
    wait_n(2);
    chk("reset_level", level, 4'b0000);
    chk("reset_result", result, 4'b0000);
    chk("reset_rel", rel_pulse, 4'b0000);
    rst = 1'b1;
    wait_n(2);

    // ch0 press/release, no repeat
    button = 4'b0001;
    wait_n(5);
    chk("c0_level_pre", level, 4'b0000);
    tick();
    chk("c0_level_rise", level, 4'b0001);
    chk("c0_result_1", result, 4'b0001);
    chk("c0_rel_quiet", rel_pulse, 4'b0000);
    tick();
    chk("c0_result_2", result, 4'b0001);
    tick();
    chk("c0_result_end", result, 4'b0000);
    chk("c0_level_held", level, 4'b0001);
    wait_n(12);
    chk("c0_no_repeat", result, 4'b0000);
    button = 4'b0000;
    wait_n(5);
    chk("c0_level_pre_fall", level, 4'b0001);
    chk("c0_rel_pre", rel_pulse, 4'b0000);
    tick();
    chk("c0_level_fall", level, 4'b0000);
    chk("c0_rel_1", rel_pulse, 4'b0001);
    chk("c0_result_quiet", result, 4'b0000);
    tick();
    chk("c0_rel_2", rel_pulse, 4'b0001);
    tick();
    chk("c0_rel_end", rel_pulse, 4'b0000);
    wait_n(4);

    // ch1 short 3-cycle press is rejected
    acc = 4'b0000;
    button = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      tick();
      acc = acc | level | result | rel_pulse;
    end
    button = 4'b0000;
    for (int t = 0; t < 10; t++) begin
      tick();
      acc = acc | level | result | rel_pulse;
    end
    chk("c1_short_press_quiet", acc, 4'b0000);

    // ch2 held 40 cycles with auto-repeat
    repeat_en = 1'b1;
    button    = 4'b0100;
    for (int t = 1; t <= 50; t++) begin
      tick();
      res_v[t] = result[2];
      rel_v[t] = rel_pulse[2];
      if (t == 40) button = 4'b0000;
    end
    exp_res = '0;
    exp_res[6]  = 1'b1; exp_res[7]  = 1'b1;
    exp_res[16] = 1'b1; exp_res[17] = 1'b1;
    exp_res[21] = 1'b1; exp_res[22] = 1'b1;
    exp_res[26] = 1'b1; exp_res[27] = 1'b1;
    exp_res[31] = 1'b1; exp_res[32] = 1'b1;
    exp_res[36] = 1'b1; exp_res[37] = 1'b1;
    exp_res[41] = 1'b1; exp_res[42] = 1'b1;
    exp_rel = '0;
    exp_rel[46] = 1'b1; exp_rel[47] = 1'b1;
    chk("c2_repeat_result_trace", 64'(res_v), 64'(exp_res));
    chk("c2_repeat_rel_trace", 64'(rel_v), 64'(exp_rel));
    wait_n(4);

    // ch2 repeat_en dropped for 3 cycles restarts the hold count
    button = 4'b0100;
    for (int t = 1; t <= 32; t++) begin
      tick();
      res_v[t] = result[2];
      if (t == 12) repeat_en = 1'b0;
      if (t == 15) repeat_en = 1'b1;
    end
    exp_res = '0;
    exp_res[6]  = 1'b1; exp_res[7]  = 1'b1;
    exp_res[25] = 1'b1; exp_res[26] = 1'b1;
    exp_res[30] = 1'b1; exp_res[31] = 1'b1;
    res_v[50:33] = '0;
    chk("c2_repeat_en_restart", 64'(res_v), 64'(exp_res));
    button    = 4'b0000;
    repeat_en = 1'b0;
    wait_n(10);

    // ch3 2-cycle release glitch is absorbed
    button = 4'b1000;
    wait_n(8);
    chk("c3_level_up", level, 4'b1000);
    lvl_and = 1'b1;
    rel_or  = 1'b0;
    button  = 4'b0000;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 2) button = 4'b1000;
      lvl_and = lvl_and & level[3];
      rel_or  = rel_or | rel_pulse[3];
    end
    chk("c3_glitch_level_kept", lvl_and, 1'b1);
    chk("c3_glitch_no_rel", rel_or, 1'b0);
    button = 4'b0000;
    wait_n(10);

    // All channels pressed together
    button = 4'b1111;
    wait_n(5);
    chk("all_level_pre", level, 4'b0000);
    tick();
    chk("all_level_rise", level, 4'b1111);
    chk("all_result_1", result, 4'b1111);
    tick();
    chk("all_result_2", result, 4'b1111);

    // Reset mid-pulse with buttons still held
    rst = 1'b0;
    #1;
    chk("rst_mid_level", level, 4'b0000);
    chk("rst_mid_result", result, 4'b0000);
    chk("rst_mid_rel", rel_pulse, 4'b0000);
    tick();
    rst = 1'b1;
    wait_n(5);
    chk("rst_after_pre", result, 4'b0000);
    tick();
    chk("rst_after_level", level, 4'b1111);
    chk("rst_after_result", result, 4'b1111);
    wait_n(2);
    chk("rst_after_result_end", result, 4'b0000);
    button = 4'b0000;
    wait_n(10);
    chk("final_idle_level", level, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
